// File: rtl/sound_pkg.sv
// Shared definitions for the main-board to sound-board command link.
package sound_pkg;

    localparam logic [5:0]  SND_IDLE_CODE = 6'h3F;
    localparam int unsigned SND_E_DIV     = 4;
    localparam int unsigned SND_CNT_W     = 11;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        GAP
    } snd_state_t;

    typedef struct packed {
        logic       hand;
        logic [5:0] code;
    } snd_cmd_t;

endpackage

// File: rtl/sound_cmd_fifo.sv
// Command queue for sound_cmd_tx: a DEPTH-entry FIFO, or a single holding register when DEPTH == 1.
module sound_cmd_fifo
    import sound_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk_4e,
    input  logic     reset,
    input  logic     push,
    input  logic     pop,
    input  snd_cmd_t din,
    output snd_cmd_t dout,
    output logic     full,
    output logic     empty,
    output logic     empty_next
);

    if (DEPTH == 1) begin : g_reg
        snd_cmd_t hold_q;
        logic     hold_v;

        // push only happens when empty and pop only when full, so they never coincide here
        always_ff @(posedge clk_4e) begin
            if (reset) begin
                hold_v <= 1'b0;
            end else if (push) begin
                hold_v <= 1'b1;
            end else if (pop) begin
                hold_v <= 1'b0;
            end
        end

        always_ff @(posedge clk_4e) begin
            if (push) begin
                hold_q <= din;
            end
        end

        assign dout       = hold_q;
        assign full       = hold_v;
        assign empty      = !hold_v;
        assign empty_next = !(push || (hold_v && !pop));
    end else begin : g_fifo
        localparam int unsigned AW = $clog2(DEPTH);

        snd_cmd_t      mem [DEPTH];
        logic [AW-1:0] wr_ptr;
        logic [AW-1:0] rd_ptr;
        logic [AW:0]   count;
        logic [AW:0]   count_nxt;

        always_comb begin
            count_nxt = count;
            case ({push, pop})
                2'b10:   count_nxt = count + (AW + 1)'(1);
                2'b01:   count_nxt = count - (AW + 1)'(1);
                default: count_nxt = count;
            endcase
        end

        always_ff @(posedge clk_4e) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= din;
                    wr_ptr      <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count_nxt;
            end
        end

        assign dout       = mem[rd_ptr];
        assign full       = (count == (AW + 1)'(DEPTH));
        assign empty      = (count == '0);
        assign empty_next = (count_nxt == '0);
    end

endmodule

// File: rtl/sound_cmd_tx.sv
// Main-board sound-command transmitter: queues codes and drives pb/hand with hold and idle-gap timing.
// Define SOUND_TX_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise a single holding register is used.
module sound_cmd_tx
    import sound_pkg::*;
#(
    parameter int unsigned HOLD_E     = 64,
    parameter int unsigned GAP_E      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk_4e,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [5:0] cmd_code,
    input  logic       cmd_hand,
    output logic [5:0] pb,
    output logic       hand,
    output logic       busy,
    output logic       null_drop
);

`ifdef SOUND_TX_FIFO_EN
    localparam bit USE_FIFO = 1'b1;
`else
    localparam bit USE_FIFO = 1'b0;
`endif

    localparam int unsigned          Q_DEPTH  = USE_FIFO ? FIFO_DEPTH : 1;
    localparam logic [SND_CNT_W-1:0] HOLD_CNT = SND_CNT_W'(SND_E_DIV * HOLD_E - 1);
    localparam logic [SND_CNT_W-1:0] GAP_CNT  = SND_CNT_W'(SND_E_DIV * GAP_E - 1);
    localparam logic [SND_CNT_W-1:0] CNT_ONE  = SND_CNT_W'(1);
    localparam snd_cmd_t             IDLE_CMD = '{hand: 1'b1, code: SND_IDLE_CODE};

    snd_state_t           state, state_nxt;
    logic [SND_CNT_W-1:0] cnt, cnt_nxt;
    logic [5:0]           drv_code, code_nxt;
    logic                 drv_hand, hand_nxt;
    logic                 null_nxt;

    snd_cmd_t push_cmd;
    snd_cmd_t head;
    logic     push;
    logic     pop;
    logic     full;
    logic     empty;
    logic     empty_next;

    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign push_cmd  = '{hand: cmd_hand, code: cmd_code};

    sound_cmd_fifo #(
        .DEPTH(Q_DEPTH)
    ) u_queue (
        .clk_4e    (clk_4e),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .din       (push_cmd),
        .dout      (head),
        .full      (full),
        .empty     (empty),
        .empty_next(empty_next)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        code_nxt  = drv_code;
        hand_nxt  = drv_hand;
        pop       = 1'b0;
        null_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head == IDLE_CMD) begin
                        null_nxt = 1'b1;
                    end else begin
                        code_nxt  = head.code;
                        hand_nxt  = head.hand;
                        cnt_nxt   = HOLD_CNT;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    code_nxt  = SND_IDLE_CODE;
                    hand_nxt  = 1'b1;
                    cnt_nxt   = GAP_CNT;
                    state_nxt = GAP;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // pb/hand are a second register stage after drv_*, giving the 2-clock handshake-to-line latency
    always_ff @(posedge clk_4e) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            drv_code  <= SND_IDLE_CODE;
            drv_hand  <= 1'b1;
            pb        <= SND_IDLE_CODE;
            hand      <= 1'b1;
            busy      <= 1'b0;
            null_drop <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            drv_code  <= code_nxt;
            drv_hand  <= hand_nxt;
            pb        <= drv_code;
            hand      <= drv_hand;
            busy      <= (state_nxt != IDLE) || !empty_next;
            null_drop <= null_nxt;
        end
    end

endmodule

// File: tb/tb_sound_cmd_tx.sv
// Scoreboard bench for sound_cmd_tx (HOLD_E=64, GAP_E=16): stimulus queues expected line events, a monitor checks them.
module tb_sound_cmd_tx;

    localparam int HOLD_CLK = 256;
    localparam int PERIOD   = 321;
    localparam int LAT      = 3;    // negedge of drive -> first negedge showing the new pattern
    localparam int GAP_MIN  = 64;

    logic       clk_4e    = 1'b0;
    logic       reset     = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [5:0] cmd_code  = 6'h3F;
    logic       cmd_hand  = 1'b1;
    logic       cmd_ready;
    logic [5:0] pb;
    logic       hand;
    logic       busy;
    logic       null_drop;

    sound_cmd_tx #(
        .HOLD_E    (64),
        .GAP_E     (16),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_4e   (clk_4e),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_code (cmd_code),
        .cmd_hand (cmd_hand),
        .pb       (pb),
        .hand     (hand),
        .busy     (busy),
        .null_drop(null_drop)
    );

    always #5 clk_4e = ~clk_4e;

    int cyc = 0;
    always @(posedge clk_4e) cyc <= cyc + 1;

    typedef struct {
        logic [5:0] code;
        logic       hand;
        int         start;
        int         dur;
    } exp_t;

    exp_t exp_q[$];
    int   null_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   last_start = -100000;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
        end
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input logic [5:0] code, input logic hnd, input bit expect_it, input int dur,
                        output int hs_c);
        int n;
        int st;
        n = 0;
        while (!cmd_ready && n < 2000) begin
            @(negedge clk_4e);
            n++;
        end
        if (!cmd_ready) check("ready_timeout", 0, 1);
        hs_c      = cyc;
        cmd_valid = 1'b1;
        cmd_code  = code;
        cmd_hand  = hnd;
        if (expect_it) begin
            st = (cyc + LAT > last_start + PERIOD) ? cyc + LAT : last_start + PERIOD;
            last_start = st;
            exp_q.push_back('{code, hnd, st, dur});
        end
        @(negedge clk_4e);
        cmd_valid = 1'b0;
        cmd_code  = 6'h3F;
        cmd_hand  = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || {hand, pb} != 7'h7F) && n < 5000) begin
            @(negedge clk_4e);
            n++;
        end
        if (n >= 5000) check("idle_timeout", 0, 1);
        repeat (4) @(negedge clk_4e);
    endtask

    initial begin : monitor
        bit         active    = 1'b0;
        logic [5:0] cur_code  = 6'h3F;
        logic       cur_hand  = 1'b1;
        int         cur_start = 0;
        int         last_end  = -100000;
        exp_t       e;
        forever begin
            @(negedge clk_4e);
            if (null_drop === 1'b1) begin
                if (null_q.size() == 0) check("null_drop_unexpected", cyc, -1);
                else check("null_drop_cycle", cyc, null_q.pop_front());
            end
            if (!active) begin
                if ({hand, pb} != 7'h7F) begin
                    active    = 1'b1;
                    cur_code  = pb;
                    cur_hand  = hand;
                    cur_start = cyc;
                    check("idle_gap_ge_64", (cyc - last_end >= GAP_MIN) ? 1 : 0, 1);
                end
            end else if ({hand, pb} == 7'h7F) begin
                active   = 1'b0;
                last_end = cyc;
                if (exp_q.size() == 0) begin
                    check("cmd_unexpected", int'(cur_code), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_code", int'(cur_code), int'(e.code));
                    check("cmd_hand", int'(cur_hand), int'(e.hand));
                    check("cmd_start_cycle", cur_start, e.start);
                    check("cmd_hold_clks", cyc - cur_start, e.dur);
                end
            end else if ({hand, pb} != {cur_hand, cur_code}) begin
                check("cmd_pattern_stable", int'({hand, pb}), int'({cur_hand, cur_code}));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int         c;
        int         c2;
        int         s;
        int         n;
        logic [9:0] idle_vec;
        idle_vec = {6'h3F, 1'b1, 1'b0, 1'b1, 1'b0};

        repeat (3) @(negedge clk_4e);
        reset = 1'b0;

        // 1: quiet line after reset
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_4e);
            check("idle_lines", int'({pb, hand, busy, cmd_ready, null_drop}), int'(idle_vec));
        end

        // 2: single command, busy profile
        send(6'h2A, 1'b1, 1'b1, HOLD_CLK, c);
        check("busy_after_accept", int'(busy), 1);
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk_4e);
            n++;
        end
        check("busy_fall_cycle", cyc, c + 322);
        wait_idle();

        // 3: back-to-back commands in order
        for (int i = 1; i <= 5; i++) begin
            send(6'(i), 1'b1, 1'b1, HOLD_CLK, c);
`ifdef SOUND_TX_FIFO_EN
            if (i == 4) check("ready_before_full", int'(cmd_ready), 1);
            if (i == 5) check("ready_low_when_full", int'(cmd_ready), 0);
`endif
        end
        wait_idle();

        // 4: idle pattern is dropped; 3F with hand low is a real command
        send(6'h3F, 1'b1, 1'b0, 0, c);
        null_q.push_back(c + 2);
        repeat (3) @(negedge clk_4e);
        check("busy_after_null", int'(busy), 0);
        wait_idle();
        send(6'h3F, 1'b0, 1'b1, HOLD_CLK, c);
        wait_idle();

        // 5: reset in the middle of a hold flushes everything
        send(6'h15, 1'b1, 1'b1, 101, c);
        s = last_start;
        send(6'h16, 1'b1, 1'b0, 0, c2);
`ifdef SOUND_TX_FIFO_EN
        send(6'h17, 1'b1, 1'b0, 0, c2);
`endif
        while (cyc < s + 100) @(negedge clk_4e);
        reset = 1'b1;
        @(negedge clk_4e);
        check("reset_pb", int'(pb), 'h3F);
        check("reset_hand", int'(hand), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_ready", int'(cmd_ready), 1);
        reset      = 1'b0;
        last_start = -100000;
        repeat (1000) @(negedge clk_4e);
        check("busy_after_flush", int'(busy), 0);

`ifndef SOUND_TX_FIFO_EN
        // 6: holding register blocks the second offer until the first is popped
        send(6'h10, 1'b1, 1'b1, HOLD_CLK, c);
        check("ready_low_while_held", int'(cmd_ready), 0);
        send(6'h11, 1'b1, 1'b1, HOLD_CLK, c2);
        check("ready_return_cycle", c2, c + 2);
        wait_idle();
`endif

        check("scoreboard_drained", exp_q.size() + null_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
